// File: rtl/gcd_pkg.sv
// Shared state encoding, default sizes and the round-robin pick helper
// used by the GCD scheduler and its datapath core.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int GCD_W = 8;
  localparam int GCD_N = 4;
  localparam int MAX_N = 32;

  // First set bit of valid at or above ptr, wrapping modulo n; 0 when none.
  function automatic logic [4:0] rr_pick(input logic [MAX_N-1:0] valid,
                                         input logic [4:0]       ptr,
                                         input int               n);
    logic [4:0] pick;
    logic       found;
    logic [5:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      idx = {1'b0, ptr} + 6'(k);
      if (idx >= 6'(n)) idx = idx - 6'(n);
      if (k < n && !found && valid[idx[4:0]]) begin
        pick  = idx[4:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/gcd_core.sv
// Iterative subtraction GCD datapath: one subtraction per cycle until an
// operand reaches zero, at which point the other operand is the result.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result
);

  logic [W-1:0] x;
  logic [W-1:0] y;

  assign done   = (x == '0) || (y == '0);
  assign result = x | y;

  // Stepping stops by itself once done, so no separate enable is needed.
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= a;
      y <= b;
    end else if (!done) begin
      if (x > y) x <= x - y;
      else       y <= y - x;
    end
  end

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin front end sharing one gcd_core between N requesters; results
// return on a single response channel tagged with the requester id.
//
// state | meaning
// IDLE  | arbitrating; grant offered to the first valid requester from ptr
// RUN   | core iterating on the latched operands
// RESP  | result presented, waiting for resp_ready
module gcd_scheduler
  import gcd_pkg::*;
#(
  parameter  int W   = GCD_W,
  parameter  int N   = GCD_N,
  localparam int IDW = $clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [IDW-1:0] resp_id,
  output logic [W-1:0]   resp_gcd,
  output logic           busy
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     gcd_q;
  logic [IDW-1:0]   grant;
  logic [MAX_N-1:0] valid_ext;
  logic             any_req;
  logic             load;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic             core_done;
  logic [W-1:0]     core_result;

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = req_valid;
  end

  assign any_req = |req_valid;
  assign grant   = IDW'(rr_pick(valid_ext, 5'(ptr_q), N));
  assign a_sel   = req_a[int'(grant)*W +: W];
  assign b_sel   = req_b[int'(grant)*W +: W];

  gcd_core #(.W(W)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .a      (a_sel),
    .b      (b_sel),
    .done   (core_done),
    .result (core_result)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req)    state_nxt = RUN;
      RUN:     if (core_done)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    load      = 1'b0;
    if (state == IDLE && any_req) begin
      req_ready = N'(1) << grant;
      load      = 1'b1;
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);
  assign resp_id    = id_q;
  assign resp_gcd   = gcd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
      id_q  <= '0;
      gcd_q <= '0;
    end else begin
      if (load) begin
        id_q  <= grant;
        ptr_q <= (grant == IDW'(N-1)) ? '0 : grant + 1'b1;
      end
      if (state == RUN && core_done) gcd_q <= core_result;
    end
  end

endmodule
